// File: rtl/dcpu_fetch_queue.sv
// Instruction-fetch front end: single-outstanding halfword bus master feeding a prefetch FIFO that presents whole 1..3 halfword instructions.
// Latency: first request on the first edge after reset; a len1 instruction is valid 1 cycle after its ack edge; >=2 cycles after a redirect.
// Backpressure: o_cyc drops when the FIFO is full; the head is held stable while i_ready=0. `define DCPU_FETCH_IMM_SEXT_EN to sign-extend len2 immediates.
module dcpu_fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    output logic              o_cyc,
    output logic [1:0]        o_stb,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [15:0]       o_dat,
    input  logic              i_ack,
    input  logic [15:0]       i_dat,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [15:0]       o_ir,
    output logic [31:0]       o_imm,
    output logic [1:0]        o_len,
    output logic [ADDR_W-1:0] o_pc
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] START_PC = {RESET_PC[ADDR_W-1:1], 1'b0};

    typedef enum logic {
        S_FETCH,
        S_FLUSH
    } state_t;

    typedef struct packed {
        logic [15:0] ir;
        logic [31:0] imm;
        logic [1:0]  len;
    } instr_t;

    state_t            state;
    logic [15:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] redirect_pc_even;
    logic [15:0]       w0;
    logic [15:0]       w1;
    logic [15:0]       w2;
    instr_t            head;
    logic              push;
    logic              pop;
    logic              unused_redirect_lsb;

    assign redirect_pc_even    = {i_redirect_pc[ADDR_W-1:1], 1'b0};
    assign unused_redirect_lsb = i_redirect_pc[0];

    // Words beyond the valid count may be stale; the decode masks them by length.
    assign w0 = fifo_mem[rd_ptr];
    assign w1 = fifo_mem[rd_ptr + PTR_W'(1)];
    assign w2 = fifo_mem[rd_ptr + PTR_W'(2)];

    always_comb begin
        head    = '0;
        head.ir = w0;
        if (w0[15:13] != 3'b111) begin
            head.len = 2'd1;
        end else if (w0[12:11] == 2'b11) begin
            head.len = 2'd3;
        end else begin
            head.len = 2'd2;
        end
        case (head.len)
`ifdef DCPU_FETCH_IMM_SEXT_EN
            2'd2:    head.imm = {{16{w1[15]}}, w1};
`else
            2'd2:    head.imm = {16'h0000, w1};
`endif
            2'd3:    head.imm = {w2, w1};
            default: head.imm = '0;
        endcase
    end

    assign o_valid = (count >= CNT_W'(head.len)) && !i_redirect && (state == S_FETCH);
    assign pop     = o_valid && i_ready;
    assign push    = (state == S_FETCH) && o_cyc && i_ack && !i_redirect;

    assign count_nxt = count + CNT_W'(push) - (pop ? CNT_W'(head.len) : '0);

    assign o_ir  = head.ir;
    assign o_imm = head.imm;
    assign o_len = head.len;
    assign o_pc  = pc;
    assign o_stb = {2{o_cyc}};
    assign o_we  = 1'b0;
    assign o_dat = '0;

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= i_dat;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state  <= S_FETCH;
            o_cyc  <= 1'b0;
            o_addr <= START_PC;
            pc     <= START_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (i_redirect) begin
                        rd_ptr <= '0;
                        wr_ptr <= '0;
                        count  <= '0;
                        pc     <= redirect_pc_even;
                        // An unacked transfer must complete at its old address; pc doubles as the restart target.
                        if (o_cyc && !i_ack) begin
                            state <= S_FLUSH;
                        end else begin
                            o_addr <= redirect_pc_even;
                            o_cyc  <= 1'b1;
                        end
                    end else begin
                        count <= count_nxt;
                        o_cyc <= (count_nxt < CNT_W'(DEPTH));
                        if (push) begin
                            wr_ptr <= wr_ptr + PTR_W'(1);
                            o_addr <= o_addr + ADDR_W'(2);
                        end
                        if (pop) begin
                            rd_ptr <= rd_ptr + PTR_W'(head.len);
                            pc     <= pc + ADDR_W'({head.len, 1'b0});
                        end
                    end
                end
                S_FLUSH: begin
                    if (i_redirect) begin
                        pc <= redirect_pc_even;
                    end
                    if (i_ack) begin
                        state  <= S_FETCH;
                        o_cyc  <= 1'b1;
                        o_addr <= i_redirect ? redirect_pc_even : pc;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_dcpu_fetch_queue.sv
// Scoreboard bench for dcpu_fetch_queue: behavioural Wishbone slave, expected instructions queued per scenario.
module tb_dcpu_fetch_queue;
    typedef struct packed {
        logic [15:0] ir;
        logic [31:0] imm;
        logic [1:0]  len;
        logic [31:0] pc;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        o_cyc;
    logic [1:0]  o_stb;
    logic        o_we;
    logic [31:0] o_addr;
    logic [15:0] o_dat;
    logic        i_ack = 1'b0;
    logic [15:0] i_dat = 16'h0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = 32'h0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [15:0] o_ir;
    logic [31:0] o_imm;
    logic [1:0]  o_len;
    logic [31:0] o_pc;

    exp_t        exp_q[$];
    logic [31:0] ack_log[$];
    logic [15:0] mem [0:1023];
    int          slave_wait = 0;
    int          wait_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    dcpu_fetch_queue dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .o_cyc(o_cyc), .o_stb(o_stb), .o_we(o_we), .o_addr(o_addr), .o_dat(o_dat),
        .i_ack(i_ack), .i_dat(i_dat),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_ir(o_ir), .o_imm(o_imm), .o_len(o_len), .o_pc(o_pc)
    );

    initial forever #5 i_clk = ~i_clk;

    // Slave: acks after slave_wait idle cycles of a held request.
    initial forever begin
        @(posedge i_clk);
        #1;
        if (o_cyc && i_reset_n) begin
            if (wait_cnt >= slave_wait) begin
                i_ack = 1'b1;
                i_dat = mem[o_addr[10:1]];
                ack_log.push_back(o_addr);
                wait_cnt = 0;
            end else begin
                i_ack = 1'b0;
                i_dat = 16'hDEAD;
                wait_cnt++;
            end
        end else begin
            i_ack = 1'b0;
            wait_cnt = 0;
        end
    end

    // Scoreboard: every accepted instruction is matched against the expected queue.
    initial forever begin
        @(negedge i_clk);
        if (i_reset_n && o_valid && i_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got ir=%h pc=%h len=%0d, required no instruction", o_ir, o_pc, o_len);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({o_ir, o_imm, o_len, o_pc} !== e) begin
                    errors++;
                    $display("FAIL pop_data: got ir=%h imm=%h len=%0d pc=%h, required ir=%h imm=%h len=%0d pc=%h",
                             o_ir, o_imm, o_len, o_pc, e.ir, e.imm, e.len, e.pc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    task automatic fill_seq();
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i + 1);
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        i_ready = 1'b0;
        i_redirect = 1'b0;
        i_redirect_pc = 32'h0;
        repeat (2) @(posedge i_clk);
        #1;
        ack_log.delete();
        exp_q.delete();
        i_reset_n = 1'b1;
    endtask

    task automatic drain(output bit done);
        done = 1'b0;
        @(posedge i_clk);
        #1;
        i_ready = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge i_clk);
            #1;
            if (exp_q.size() == 0) done = 1'b1;
        end
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        @(negedge i_clk);
        checks++;
        if ({o_cyc, o_stb, o_we, o_valid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got cyc=%b stb=%b we=%b valid=%b, required all 0", o_cyc, o_stb, o_we, o_valid);
        end
        checks++;
        if (o_addr !== 32'h0 || o_pc !== 32'h0 || o_dat !== 16'h0) begin
            errors++;
            $display("FAIL reset_addr: got addr=%h pc=%h dat=%h, required 0", o_addr, o_pc, o_dat);
        end
    endtask

    task automatic test_sequential();
        bit ok;
        fill_seq();
        slave_wait = 0;
        do_reset();
        @(negedge i_clk);
        checks++;
        if (o_cyc !== 1'b0) begin errors++; $display("FAIL seq_cyc_pre: got %b, required 0", o_cyc); end
        @(negedge i_clk);
        checks++;
        if (o_cyc !== 1'b1 || o_stb !== 2'b11 || o_addr !== 32'h0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL seq_first_req: got cyc=%b stb=%b addr=%h valid=%b, required 1 11 0 0", o_cyc, o_stb, o_addr, o_valid);
        end
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b1 || o_ir !== 16'h0001 || o_pc !== 32'h0 || o_len !== 2'd1) begin
            errors++;
            $display("FAIL seq_first_valid: got valid=%b ir=%h pc=%h len=%0d, required 1 0001 0 1", o_valid, o_ir, o_pc, o_len);
        end
        repeat (6) @(negedge i_clk);
        checks++;
        if (ack_log.size() != 4 || ack_log[0] !== 32'h0 || ack_log[1] !== 32'h2 ||
            ack_log[2] !== 32'h4 || ack_log[3] !== 32'h6) begin
            errors++;
            $display("FAIL seq_full_acks: got %0d acks, required 4 acks at 0,2,4,6", ack_log.size());
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            checks++;
            if (o_cyc !== 1'b0 || o_valid !== 1'b1 || o_ir !== 16'h0001 || o_pc !== 32'h0) begin
                errors++;
                $display("FAIL seq_hold: got cyc=%b valid=%b ir=%h pc=%h, required 0 1 0001 0", o_cyc, o_valid, o_ir, o_pc);
            end
        end
        for (int k = 0; k < 8; k++) exp_q.push_back('{16'(k + 1), 32'h0, 2'd1, 32'(2 * k)});
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL seq_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
        checks++;
        if (((ack_log.size() > 4) ? ack_log[4] : 32'hFFFF_FFFF) !== 32'h8) begin
            errors++;
            $display("FAIL seq_resume_addr: got %h, required 00000008", (ack_log.size() > 4) ? ack_log[4] : 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_mixed_len();
        bit ok;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
        mem[0] = 16'hE000; mem[1] = 16'h1234; mem[2] = 16'hF800; mem[3] = 16'h5678; mem[4] = 16'h9ABC;
        slave_wait = 0;
        do_reset();
        exp_q.push_back('{16'hE000, 32'h0000_1234, 2'd2, 32'h0});
        exp_q.push_back('{16'hF800, 32'h9ABC_5678, 2'd3, 32'h4});
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL mixed_a_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end

        mem[0] = 16'hE000; mem[1] = 16'h8001; mem[2] = 16'hF000; mem[3] = 16'h7FFF; mem[4] = 16'hC123;
        mem[5] = 16'hF800; mem[6] = 16'h8003; mem[7] = 16'h8004; mem[8] = 16'hE800; mem[9] = 16'h0005;
        do_reset();
`ifdef DCPU_FETCH_IMM_SEXT_EN
        exp_q.push_back('{16'hE000, 32'hFFFF_8001, 2'd2, 32'h0});
`else
        exp_q.push_back('{16'hE000, 32'h0000_8001, 2'd2, 32'h0});
`endif
        exp_q.push_back('{16'hF000, 32'h0000_7FFF, 2'd2, 32'h4});
        exp_q.push_back('{16'hC123, 32'h0000_0000, 2'd1, 32'h8});
        exp_q.push_back('{16'hF800, 32'h8004_8003, 2'd3, 32'hA});
        exp_q.push_back('{16'hE800, 32'h0000_0005, 2'd2, 32'h10});
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL mixed_b_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_redirect_flush();
        bit ok;
        fill_seq();
        slave_wait = 2;
        do_reset();
        @(posedge i_clk);
        #1;
        i_redirect = 1'b1;
        i_redirect_pc = 32'h100;
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_valid_redir: got %b, required 0", o_valid); end
        @(posedge i_clk);
        #1;
        i_redirect = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge i_clk);
            checks++;
            if (o_cyc !== 1'b1 || o_stb !== 2'b11 || o_addr !== 32'h0 || o_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_hold: got cyc=%b stb=%b addr=%h valid=%b, required 1 11 0 0", o_cyc, o_stb, o_addr, o_valid);
            end
        end
        @(negedge i_clk);
        checks++;
        if (o_cyc !== 1'b1 || o_addr !== 32'h100 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_restart: got cyc=%b addr=%h valid=%b, required 1 00000100 0", o_cyc, o_addr, o_valid);
        end
        exp_q.push_back('{16'h0081, 32'h0, 2'd1, 32'h100});
        exp_q.push_back('{16'h0082, 32'h0, 2'd1, 32'h102});
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL flush_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
        checks++;
        if (ack_log.size() < 2 || ack_log[0] !== 32'h0 || ack_log[1] !== 32'h100) begin
            errors++;
            $display("FAIL flush_ack_addrs: got %0d acks first=%h, required 0 then 100", ack_log.size(),
                     (ack_log.size() > 0) ? ack_log[0] : 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_redirect_in_flush();
        bit ok;
        fill_seq();
        slave_wait = 2;
        do_reset();
        @(posedge i_clk);
        #1;
        i_redirect = 1'b1;
        i_redirect_pc = 32'h100;
        @(posedge i_clk);
        #1;
        i_redirect_pc = 32'h201;
        @(posedge i_clk);
        #1;
        i_redirect = 1'b0;
        exp_q.push_back('{16'h0101, 32'h0, 2'd1, 32'h200});
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL reflush_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
        checks++;
        if (ack_log.size() < 2 || ack_log[1] !== 32'h200) begin
            errors++;
            $display("FAIL reflush_addr: got %h, required 00000200", (ack_log.size() > 1) ? ack_log[1] : 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_redirect_collision();
        bit ok;
        fill_seq();
        slave_wait = 0;
        do_reset();
        @(posedge i_clk);
        #1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b1;
        i_redirect = 1'b1;
        i_redirect_pc = 32'h40;
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL coll_valid_masked: got %b, required 0", o_valid); end
        @(posedge i_clk);
        #1;
        i_redirect = 1'b0;
        i_ready = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b0 || o_cyc !== 1'b1 || o_addr !== 32'h40) begin
            errors++;
            $display("FAIL coll_empty: got valid=%b cyc=%b addr=%h, required 0 1 00000040", o_valid, o_cyc, o_addr);
        end
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b1 || o_ir !== 16'h0021 || o_pc !== 32'h40) begin
            errors++;
            $display("FAIL coll_first: got valid=%b ir=%h pc=%h, required 1 0021 00000040", o_valid, o_ir, o_pc);
        end
        checks++;
        if (ack_log.size() < 2 || ack_log[1] !== 32'h2) begin
            errors++;
            $display("FAIL coll_ack_same_cycle: got %0d acks, required ack at 2 during redirect", ack_log.size());
        end
        exp_q.push_back('{16'h0021, 32'h0, 2'd1, 32'h40});
        exp_q.push_back('{16'h0022, 32'h0, 2'd1, 32'h42});
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL coll_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_async_reset();
        bit ok;
        fill_seq();
        slave_wait = 0;
        do_reset();
        @(posedge i_clk);
        #1;
        @(posedge i_clk);
        #1;
        checks++;
        if (o_cyc !== 1'b1 || o_addr !== 32'h2) begin
            errors++;
            $display("FAIL arst_pre: got cyc=%b addr=%h, required 1 00000002", o_cyc, o_addr);
        end
        #2;
        i_reset_n = 1'b0;
        #1;
        checks++;
        if (o_cyc !== 1'b0 || o_stb !== 2'b00 || o_addr !== 32'h0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL arst_immediate: got cyc=%b stb=%b addr=%h valid=%b, required 0 00 0 0", o_cyc, o_stb, o_addr, o_valid);
        end
        ack_log.delete();
        exp_q.delete();
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        exp_q.push_back('{16'h0001, 32'h0, 2'd1, 32'h0});
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL arst_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
        checks++;
        if (ack_log.size() == 0 || ack_log[0] !== 32'h0) begin
            errors++;
            $display("FAIL arst_restart_addr: got %h, required 00000000", (ack_log.size() > 0) ? ack_log[0] : 32'hFFFF_FFFF);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_mixed_len();
        test_redirect_flush();
        test_redirect_in_flush();
        test_redirect_collision();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dcpu_fetch_queue.md
Name: dcpu_fetch_queue

Overview:
Parametrised instruction-fetch front end for the dcpu core.
- Replaces the core's fixed FETCH1/FETCH2/FETCH3 sequencing with a Wishbone-style master and a halfword prefetch FIFO.
- Hands the execute stage whole variable-length instructions: opcode, 0–2 immediate halfwords, length and PC.
- Supports branch redirect with flush of the FIFO and any in-flight bus transfer.

Parameters:
ADDR_W, 32, width of fetch address and PC; 16..32.
DEPTH, 4, prefetch FIFO depth in halfwords; power of two, minimum 4.
RESET_PC, 0, fetch address after reset.

Ports:
i_clk  in  1  clock, all state on rising edge.
i_reset_n  in  1  reset, asynchronous assert, active-low.
o_cyc  out  1  bus cycle active.
o_stb  out  2  byte strobes; 2'b11 while requesting, else 2'b00.
o_we  out  1  tied 0.
o_addr  out  ADDR_W  fetch address, always even.
o_dat  out  16  tied 0.
i_ack  in  1  transfer complete; i_dat valid this cycle.
i_dat  in  16  read data.
i_redirect  in  1  flush and restart fetch at i_redirect_pc.
i_redirect_pc  in  ADDR_W  new PC; bit 0 ignored (forced 0).
o_valid  out  1  complete instruction at queue head.
i_ready  in  1  consumer accepts head instruction.
o_ir  out  16  opcode halfword.
o_imm  out  32  immediate; word1 in [15:0], word2 in [31:16].
o_len  out  2  instruction length in halfwords, 1..3.
o_pc  out  ADDR_W  address of opcode halfword.

Behaviour:
- Reset (async, while i_reset_n=0):
  - o_cyc=0, o_stb=0, o_addr=RESET_PC.
  - FIFO empty, o_valid=0, head pc=RESET_PC, state=FETCH.
- Length decode on head halfword h:
  - h[15:13]!=3'b111 → len 1.
  - else h[12:11]==2'b11 → len 3.
  - else → len 2.
- o_valid = (count >= len(head)) && !i_redirect && state==FETCH. Combinational from registered FIFO state.
- o_imm (ext disabled, see Optional Feature): unused halfwords read 0.
  - len1: 0.
  - len2: {16'h0, w1}.
  - len3: {w2, w1}.
- Pop: on o_valid && i_ready, remove o_len halfwords and add 2*o_len to head pc. Wraps modulo 2^ADDR_W.
- States:
  - FETCH: request while space is available.
  - FLUSH: wait out the aborted transfer.
- FETCH:
  - Bus is classic single-outstanding: o_cyc=o_stb-active held until i_ack.
  - On i_ack: push i_dat and advance o_addr by 2, wrapping modulo 2^ADDR_W.
  - o_cyc for the next cycle is registered; asserted iff count after this edge's push/pop < DEPTH.
  - Zero-wait slave gives 1 halfword/cycle sustained.
  - Push and pop in the same cycle are both applied; count += 1 - len.
  - Full (count==DEPTH): o_cyc drops; never push into a full FIFO.
- Redirect (i_redirect=1) has priority over push and pop in that cycle:
  - FIFO cleared; head pc and o_addr-target set to i_redirect_pc.
  - Same-cycle i_ack data is discarded.
  - If o_cyc=1 and no i_ack: enter FLUSH, keep o_cyc/o_stb asserted at the old address until i_ack, discard data, then set o_addr=new pc and return to FETCH.
  - A further redirect during FLUSH replaces the stored target.
  - Otherwise: remain in FETCH, first request at new pc on the next cycle.
- Latency:
  - First o_cyc on first edge after reset release.
  - Zero-wait bus: len1 instruction valid 1 cycle after its ack edge.
  - Post-redirect first o_valid ≥2 cycles after redirect.
- o_ir/o_imm/o_len/o_pc are don't-care when o_valid=0, but must be stable while o_valid=1 && i_ready=0.

Optional Feature:
DCPU_FETCH_IMM_SEXT_EN
- Defined: for len 2, o_imm = sign-extension of w1 to 32 bits.
- Undefined: zero-extended as above.
- len 1 and len 3 are unaffected in both cases.

Test Plan:
- Reset release, zero-wait slave returning 16'h0001,16'h0002,... from addr 0 → o_addr 0,2,4,…; o_valid for ir=0001 pc=0 len=1, then ir=0002 pc=2.
- Memory at 0: E000,1234,F800,5678,9ABC (len2 then len3), i_ready=1 → {ir=E000, imm=00001234, len=2, pc=0}, then {ir=F800, imm=9ABC5678, len=3, pc=4}. With macro and w1=8001: len2 imm=FFFF8001.
- i_ready=0, DEPTH=4 → exactly 4 acks, then o_cyc=0 and o_valid held stable; raise i_ready → fetch resumes at addr 8.
- Slave with 3-cycle ack, i_redirect pc=0x100 at wait-cycle 1 → o_cyc held at old addr until ack, data discarded, next request at 0x100, first o_valid has pc=0x100.
- i_redirect on same cycle as o_valid&&i_ready and i_ack → no pop counted, ack data dropped, FIFO empty next cycle.
- Assert i_reset_n=0 mid-transfer (o_cyc=1) → o_cyc/o_stb 0 immediately (async); after release, fetch restarts at RESET_PC.
